// File: rtl/lc3_ctrl_seq.sv
// LC-3 control sequencer: fetch/decode/execute for the non-trap subset, with a
// ready handshake on memory accesses and a wait-state timeout into HALT.
//
// state  | meaning
// FETCH1 | MAR <- PC, PC <- PC+1 (idle one cycle after reset)
// FETCH2 | instruction read wait, MDR <- mem on ready
// FETCH3 | IR <- MDR
// DECODE | dispatch on IR[15:12]
// ALU    | ADD/AND/NOT write-back
// BR     | conditional PC <- PC + off9
// JMP    | PC <- BaseR
// JSR1   | R7 <- PC
// JSR2   | PC <- PC + off11 or BaseR
// LEA    | DR <- PC + off9
// LADDR  | MAR <- effective address (LD/LDR)
// LRD    | data read wait
// LWB    | DR <- MDR
// SADDR  | MAR <- effective address (ST/STR)
// SDAT   | MDR <- SR
// SWR    | data write wait
// HALT   | fault, leaves only on reset
module lc3_ctrl_seq #(
  parameter int unsigned WAIT_LIMIT = 255,
  parameter int unsigned CW         = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] IR,
  input  logic        N,
  input  logic        Z,
  input  logic        P,
  input  logic        MEM_R,
  output logic        LD_MAR,
  output logic        LD_MDR,
  output logic        LD_IR,
  output logic        LD_PC,
  output logic        LD_REG,
  output logic        LD_CC,
  output logic        GATE_PC,
  output logic        GATE_MDR,
  output logic        GATE_ALU,
  output logic        GATE_MARMUX,
  output logic [1:0]  PCMUX,
  output logic        ADDR1MUX,
  output logic [1:0]  ADDR2MUX,
  output logic        SR2MUX,
  output logic [1:0]  ALUK,
  output logic        DR_R7,
  output logic        SR1_SEL,
  output logic        MIO_EN,
  output logic        R_W,
  output logic        ILLEGAL,
  output logic        MEM_ERR,
  output logic [4:0]  STATE
);

  typedef enum logic [4:0] {
    S_FETCH1 = 5'd0,  S_FETCH2 = 5'd1,  S_FETCH3 = 5'd2,  S_DECODE = 5'd3,
    S_ALU    = 5'd4,  S_BR     = 5'd5,  S_JMP    = 5'd6,  S_JSR1   = 5'd7,
    S_JSR2   = 5'd8,  S_LEA    = 5'd9,  S_LADDR  = 5'd10, S_LRD    = 5'd11,
    S_LWB    = 5'd12, S_SADDR  = 5'd13, S_SDAT   = 5'd14, S_SWR    = 5'd15,
    S_HALT   = 5'd31
  } state_t;

  localparam logic [CW-1:0] LIMIT  = CW'(WAIT_LIMIT);
  localparam bit            TMO_EN = (WAIT_LIMIT != 0);

  state_t          state_q, state_d, wait_done;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ill_q, ill_d, merr_q, merr_d, run_q;
  logic            in_wait, tmo_hit;
  logic [3:0]      op;
  logic            unused_ir;

  assign op        = IR[15:12];
  assign tmo_hit   = TMO_EN && (cnt_q == LIMIT);
  assign unused_ir = ^{IR[8:6], IR[4:0]};
  assign STATE     = state_q;
  assign ILLEGAL   = ill_q;
  assign MEM_ERR   = merr_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_FETCH1;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
      merr_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
      merr_q  <= merr_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_PC = 1'b0;
    LD_REG = 1'b0; LD_CC = 1'b0;
    GATE_PC = 1'b0; GATE_MDR = 1'b0; GATE_ALU = 1'b0; GATE_MARMUX = 1'b0;
    PCMUX = 2'd0; ADDR1MUX = 1'b0; ADDR2MUX = 2'd0; SR2MUX = 1'b0;
    ALUK = 2'd0; DR_R7 = 1'b0; SR1_SEL = 1'b0; MIO_EN = 1'b0; R_W = 1'b0;
    state_d   = state_q;
    cnt_d     = '0;
    ill_d     = ill_q;
    merr_d    = merr_q;
    in_wait   = 1'b0;
    wait_done = S_FETCH1;

    case (state_q)
      S_FETCH1: if (run_q) begin
        LD_MAR = 1'b1; GATE_PC = 1'b1; LD_PC = 1'b1;
        state_d = S_FETCH2;
      end
      S_FETCH2: begin
        MIO_EN = 1'b1; LD_MDR = MEM_R;
        in_wait = 1'b1; wait_done = S_FETCH3;
      end
      S_FETCH3: begin
        GATE_MDR = 1'b1; LD_IR = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (op)
          4'b0001, 4'b0101, 4'b1001: state_d = S_ALU;
          4'b0000:                   state_d = S_BR;
          4'b1100:                   state_d = S_JMP;
          4'b0100:                   state_d = S_JSR1;
          4'b1110:                   state_d = S_LEA;
          4'b0010, 4'b0110:          state_d = S_LADDR;
          4'b0011, 4'b0111:          state_d = S_SADDR;
          default: begin
            state_d = S_HALT;
            ill_d   = 1'b1;
          end
        endcase
      end
      S_ALU: begin
        GATE_ALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        case (op)
          4'b0001: begin ALUK = 2'd0; SR2MUX = IR[5]; end
          4'b0101: begin ALUK = 2'd1; SR2MUX = IR[5]; end
          default: ALUK = 2'd2;
        endcase
        state_d = S_FETCH1;
      end
      S_BR: begin
        if ((IR[11] & N) | (IR[10] & Z) | (IR[9] & P)) begin
          LD_PC = 1'b1; PCMUX = 2'd2; ADDR2MUX = 2'd2;
        end
        state_d = S_FETCH1;
      end
      S_JMP: begin
        LD_PC = 1'b1; PCMUX = 2'd2; ADDR1MUX = 1'b1;
        state_d = S_FETCH1;
      end
      S_JSR1: begin
        GATE_PC = 1'b1; LD_REG = 1'b1; DR_R7 = 1'b1;
        state_d = S_JSR2;
      end
      S_JSR2: begin
        LD_PC = 1'b1; PCMUX = 2'd2;
        if (IR[11]) ADDR2MUX = 2'd3;
        else        ADDR1MUX = 1'b1;
        state_d = S_FETCH1;
      end
      S_LEA: begin
        GATE_MARMUX = 1'b1; LD_REG = 1'b1; ADDR2MUX = 2'd2;
        state_d = S_FETCH1;
      end
      // IR[14] separates the base+offset6 forms (LDR/STR) from PC-relative
      S_LADDR, S_SADDR: begin
        GATE_MARMUX = 1'b1; LD_MAR = 1'b1;
        if (IR[14]) begin ADDR1MUX = 1'b1; ADDR2MUX = 2'd1; end
        else        ADDR2MUX = 2'd2;
        state_d = (state_q == S_LADDR) ? S_LRD : S_SDAT;
      end
      S_LRD: begin
        MIO_EN = 1'b1; LD_MDR = MEM_R;
        in_wait = 1'b1; wait_done = S_LWB;
      end
      S_LWB: begin
        GATE_MDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        state_d = S_FETCH1;
      end
      S_SDAT: begin
        SR1_SEL = 1'b1; ALUK = 2'd3; GATE_ALU = 1'b1; LD_MDR = 1'b1;
        state_d = S_SWR;
      end
      S_SWR: begin
        MIO_EN = 1'b1; R_W = 1'b1;
        in_wait = 1'b1; wait_done = S_FETCH1;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH1;
    endcase

    // Ready on the limit cycle still completes the access.
    if (in_wait) begin
      if (MEM_R) begin
        state_d = wait_done;
      end else if (tmo_hit) begin
        state_d = S_HALT;
        merr_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_lc3_ctrl_seq.sv
// Self-checking bench for lc3_ctrl_seq: per-instruction expected state walks
// built from the opcode and memory wait pattern, checked every cycle.
module tb_lc3_ctrl_seq;

  localparam int WL = 4;

  logic        CLK, RST_N, N, Z, P, MEM_R;
  logic [15:0] IR;
  logic LD_MAR, LD_MDR, LD_IR, LD_PC, LD_REG, LD_CC;
  logic GATE_PC, GATE_MDR, GATE_ALU, GATE_MARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic ADDR1MUX, SR2MUX, DR_R7, SR1_SEL, MIO_EN, R_W, ILLEGAL, MEM_ERR;
  logic [4:0] STATE;

  lc3_ctrl_seq #(.WAIT_LIMIT(WL), .CW(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .IR(IR), .N(N), .Z(Z), .P(P), .MEM_R(MEM_R),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_PC(LD_PC),
    .LD_REG(LD_REG), .LD_CC(LD_CC), .GATE_PC(GATE_PC), .GATE_MDR(GATE_MDR),
    .GATE_ALU(GATE_ALU), .GATE_MARMUX(GATE_MARMUX), .PCMUX(PCMUX),
    .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .SR2MUX(SR2MUX), .ALUK(ALUK),
    .DR_R7(DR_R7), .SR1_SEL(SR1_SEL), .MIO_EN(MIO_EN), .R_W(R_W),
    .ILLEGAL(ILLEGAL), .MEM_ERR(MEM_ERR), .STATE(STATE)
  );

  typedef struct packed {
    logic ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc;
    logic g_pc, g_mdr, g_alu, g_marmux;
    logic [1:0] pcmux; logic a1; logic [1:0] a2; logic sr2; logic [1:0] aluk;
    logic dr7, sr1, mio, rw;
  } outs_t;

  typedef struct { int st; bit mr; bit ill; bit merr; } step_t;

  outs_t dut_o;
  assign dut_o = {LD_MAR, LD_MDR, LD_IR, LD_PC, LD_REG, LD_CC,
                  GATE_PC, GATE_MDR, GATE_ALU, GATE_MARMUX,
                  PCMUX, ADDR1MUX, ADDR2MUX, SR2MUX, ALUK,
                  DR_R7, SR1_SEL, MIO_EN, R_W};

  int     tests = 0, fails = 0;
  step_t  q[$];
  bit     exp_ill = 0, exp_merr = 0;
  int     last_len;
  logic [4:0] ret_state;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Outputs each state must show, straight from the control-word table.
  function automatic outs_t exp_outs(int st, logic [15:0] ir, logic n, logic z,
                                     logic p, logic mr);
    outs_t o = '0;
    case (st)
      0:  begin o.ld_mar = 1; o.g_pc = 1; o.ld_pc = 1; end
      1:  begin o.mio = 1; o.ld_mdr = mr; end
      2:  begin o.g_mdr = 1; o.ld_ir = 1; end
      4:  begin
            o.g_alu = 1; o.ld_reg = 1; o.ld_cc = 1;
            o.aluk = (ir[15:12] == 4'h1) ? 2'd0 : (ir[15:12] == 4'h5) ? 2'd1 : 2'd2;
            o.sr2  = (ir[15:12] != 4'h9) && ir[5];
          end
      5:  if ((ir[11] && n) || (ir[10] && z) || (ir[9] && p)) begin
            o.ld_pc = 1; o.pcmux = 2; o.a2 = 2;
          end
      6:  begin o.ld_pc = 1; o.pcmux = 2; o.a1 = 1; end
      7:  begin o.g_pc = 1; o.ld_reg = 1; o.dr7 = 1; end
      8:  begin
            o.ld_pc = 1; o.pcmux = 2;
            if (ir[11]) o.a2 = 3; else o.a1 = 1;
          end
      9:  begin o.g_marmux = 1; o.ld_reg = 1; o.a2 = 2; end
      10, 13: begin
            o.g_marmux = 1; o.ld_mar = 1;
            if (ir[14]) begin o.a1 = 1; o.a2 = 1; end else o.a2 = 2;
          end
      11: begin o.mio = 1; o.ld_mdr = mr; end
      12: begin o.g_mdr = 1; o.ld_reg = 1; o.ld_cc = 1; end
      14: begin o.sr1 = 1; o.aluk = 3; o.g_alu = 1; o.ld_mdr = 1; end
      15: begin o.mio = 1; o.rw = 1; end
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic void push(int st, bit mr);
    step_t s;
    s.st = st; s.mr = mr; s.ill = exp_ill; s.merr = exp_merr;
    q.push_back(s);
  endfunction

  function automatic void push_nw(int st);
    push(st, 1'($urandom_range(0, 1)));
  endfunction

  function automatic void halt_tail();
    for (int i = 0; i < 3; i++) push_nw(31);
  endfunction

  // w not-ready cycles, then ready; returns 0 if the timeout fires first.
  function automatic bit add_wait(int st, int w);
    for (int i = 0; i < w; i++) begin
      push(st, 1'b0);
      if (WL != 0 && i == WL) begin
        exp_merr = 1;
        halt_tail();
        return 0;
      end
    end
    push(st, 1'b1);
    return 1;
  endfunction

  function automatic void build(logic [15:0] ir, int wf, int wm);
    q.delete();
    push_nw(0);
    if (!add_wait(1, wf)) return;
    push_nw(2);
    push_nw(3);
    case (ir[15:12])
      4'h1, 4'h5, 4'h9: push_nw(4);
      4'h0: push_nw(5);
      4'hC: push_nw(6);
      4'h4: begin push_nw(7); push_nw(8); end
      4'hE: push_nw(9);
      4'h2, 4'h6: begin
        push_nw(10);
        if (add_wait(11, wm)) push_nw(12);
      end
      4'h3, 4'h7: begin
        push_nw(13); push_nw(14);
        void'(add_wait(15, wm));
      end
      default: begin exp_ill = 1; halt_tail(); end
    endcase
  endfunction

  task automatic run_ins(string name, logic [15:0] ir, logic n, logic z,
                         logic p, int wf, int wm);
    outs_t e;
    IR = ir; N = n; Z = z; P = p;
    build(ir, wf, wm);
    for (int i = 0; i < q.size(); i++) begin
      @(negedge CLK);
      MEM_R = q[i].mr;
      #1;
      e = exp_outs(q[i].st, ir, n, z, p, q[i].mr);
      chk({name, "_state"}, 32'(STATE), 32'(q[i].st));
      chk({name, "_outs"}, 32'(dut_o), 32'(e));
      chk({name, "_flags"}, {30'd0, ILLEGAL, MEM_ERR}, {30'd0, q[i].ill, q[i].merr});
    end
    @(posedge CLK);
    #1;
    ret_state = STATE;
    last_len  = q.size();
  endtask

  task automatic do_reset();
    #3 RST_N = 1'b0;
    exp_ill = 0; exp_merr = 0;
    MEM_R = 1'b1;
    @(negedge CLK); #1;
    chk("rst_state", 32'(STATE), 32'd0);
    chk("rst_outs", 32'(dut_o), 32'd0);
    chk("rst_flags", {30'd0, ILLEGAL, MEM_ERR}, 32'd0);
    @(posedge CLK); #2;
    RST_N = 1'b1;
    @(negedge CLK); #1;
    chk("post_rst_idle_outs", 32'(dut_o), 32'd0);
    chk("post_rst_idle_state", 32'(STATE), 32'd0);
  endtask

  initial begin
    outs_t o;
    int n_f2;
    RST_N = 1'b0; IR = '0; N = 0; Z = 0; P = 0; MEM_R = 1'b1;

    // literal pins on the model itself
    o = exp_outs(4, 16'h1265, 0, 0, 0, 0);
    chk("pin_add_sr2", 32'(o.sr2), 32'd1);
    chk("pin_add_aluk", 32'(o.aluk), 32'd0);
    o = exp_outs(5, 16'h0A02, 0, 1, 0, 0);
    chk("pin_br_nt_ldpc", 32'(o.ld_pc), 32'd0);
    o = exp_outs(8, 16'h4803, 0, 0, 0, 0);
    chk("pin_jsr_a2", 32'(o.a2), 32'd3);
    o = exp_outs(8, 16'h4080, 0, 0, 0, 0);
    chk("pin_jsrr_a1", 32'(o.a1), 32'd1);
    o = exp_outs(13, 16'h7A7F, 0, 0, 0, 0);
    chk("pin_str_a2", 32'(o.a2), 32'd1);

    do_reset();
    run_ins("add", 16'h1265, 0, 0, 0, 0, 0);
    chk("add_len", last_len, 5);
    chk("add_ret", 32'(ret_state), 32'd0);
    run_ins("br_nt", 16'h0A02, 0, 1, 0, 0, 0);
    run_ins("br_t", 16'h0A02, 0, 0, 1, 1, 0);
    o = exp_outs(5, 16'h0A02, 0, 0, 1, 0);
    chk("pin_br_t_pcmux", 32'(o.pcmux), 32'd2);
    run_ins("jsr", 16'h4803, 0, 0, 0, 0, 0);
    chk("jsr_len", last_len, 6);
    run_ins("jsrr", 16'h4080, 0, 0, 0, 0, 0);
    run_ins("and", 16'h5042, 0, 0, 0, 0, 0);
    run_ins("not", 16'h927F, 0, 0, 0, 0, 0);
    run_ins("jmp", 16'hC1C0, 0, 0, 0, 0, 0);
    run_ins("lea", 16'hE005, 0, 0, 0, 0, 0);
    run_ins("ld", 16'h2205, 0, 0, 0, 1, 2);
    run_ins("ldr", 16'h6243, 0, 0, 0, 0, 0);
    chk("ldr_len", last_len, 7);
    run_ins("str", 16'h7A7F, 0, 0, 0, 0, 3);
    chk("str_len", last_len, 10);
    run_ins("st_limit", 16'h3402, 0, 0, 0, 2, WL);
    chk("st_limit_ret", 32'(ret_state), 32'd0);
    run_ins("trap", 16'hF025, 0, 0, 0, 0, 0);
    chk("trap_ill", 32'(ILLEGAL), 32'd1);

    do_reset();
    run_ins("tmo", 16'h1265, 0, 0, 0, 20, 0);
    n_f2 = 0;
    for (int i = 0; i < q.size(); i++) if (q[i].st == 1) n_f2++;
    chk("tmo_wait_cycles", n_f2, 5);
    chk("tmo_merr", 32'(MEM_ERR), 32'd1);
    chk("tmo_state", 32'(STATE), 32'd31);

    do_reset();
    @(negedge CLK); MEM_R = 1'b0; #1;
    chk("mid_f1", 32'(STATE), 32'd0);
    @(negedge CLK); #1;
    chk("mid_mio", 32'(MIO_EN), 32'd1);
    #2 RST_N = 1'b0;
    #1;
    chk("mid_rst_mio", 32'(MIO_EN), 32'd0);
    chk("mid_rst_state", 32'(STATE), 32'd0);

    do_reset();
    run_ins("add2", 16'h1265, 0, 0, 0, 0, 0);
    chk("add2_ret", 32'(ret_state), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
